// File: rtl/sccb_if.sv
// SCCB master bus bundle.
// Carries the request handshake from the configuration sequencer
// (i_start/i_rw/i_address/i_data, o_ready), the read-back result
// (o_rd_data/o_rd_valid) and the SIOC/SIOD pad signals
// (o_sioc, o_siod_out/o_siod_oe for the tristate, i_siod from the pad).
// master: the sccb_master side. slave: the sequencer/pad side.
interface sccb_if #(
  parameter int ADDR_BYTES = 1
);
  logic                    i_start;
  logic                    i_rw;
  logic [8*ADDR_BYTES-1:0] i_address;
  logic [7:0]              i_data;
  logic                    i_siod;
  logic                    o_sioc;
  logic                    o_siod_out;
  logic                    o_siod_oe;
  logic                    o_ready;
  logic [7:0]              o_rd_data;
  logic                    o_rd_valid;

  modport master (
    input  i_start, i_rw, i_address, i_data, i_siod,
    output o_sioc, o_siod_out, o_siod_oe, o_ready, o_rd_data, o_rd_valid
  );

  modport slave (
    output i_start, i_rw, i_address, i_data, i_siod,
    input  o_sioc, o_siod_out, o_siod_oe, o_ready, o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB master for camera register writes and reads.
// A write sends START, ID, address byte(s), data, STOP, then an idle GAP.
// A read sends START, ID, address byte(s), STOP, GAP, then START, ID|1,
// clocks in one byte (SIOD released, NA bit driven 1), STOP, GAP.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high reset
//   bus      sccb_if.master: request handshake, read result, SIOC/SIOD pads
module sccb_master #(
  parameter int         CLK_FREQUENCY  = 25000000,
  parameter int         SCCB_FREQUENCY = 100000,
  parameter int         ADDR_BYTES     = 1,
  parameter logic [7:0] DEVICE_ID      = 8'h42,
  parameter int         GAP_BITS       = 2
) (
  input  logic   i_clk,
  input  logic   i_reset,
  sccb_if.master bus
);
  localparam int CLK_PER_BIT = CLK_FREQUENCY / SCCB_FREQUENCY;
  localparam int Q           = CLK_PER_BIT / 4;
  localparam int GAP_CYC     = 4 * Q * GAP_BITS;
  localparam int TMAX        = (GAP_CYC > 2 * Q) ? GAP_CYC : 2 * Q;
  localparam int TW          = $clog2(TMAX + 1);

  if (CLK_PER_BIT < 8) begin : g_chk_rate
    $error("sccb_master: CLK_FREQUENCY/SCCB_FREQUENCY must be >= 8");
  end
  if (ADDR_BYTES != 1 && ADDR_BYTES != 2) begin : g_chk_addr
    $error("sccb_master: ADDR_BYTES must be 1 or 2");
  end

  typedef enum logic [3:0] {
    IDLE, START, BIT_LOW, BIT_DATA, BIT_HIGH,
    STOP_1, STOP_2, STOP_3, STOP_4, GAP
  } state_t;

  state_t                  state, state_nxt;
  logic [TW-1:0]           timer, dur_m1;
  logic [3:0]              bit_cnt;
  logic [1:0]              byte_cnt, last_byte;
  logic                    phase;      // 0: ID+address(+data), 1: read ID + read byte
  logic                    rw_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [15:0]             addr_w;
  logic [7:0]              data_q, rx_q, rd_data_q, tx_byte;
  logic                    rd_valid_q;
  logic                    siod_q, oe_q;  // pad values of the previous cycle
  logic                    tick, ninth, rx_byte, phase_done;
  logic                    sioc, siod, oe;

  assign addr_w    = 16'(addr_q);
  assign ninth     = (bit_cnt == 4'd8);
  assign rx_byte   = phase && (byte_cnt == 2'd1);
  assign last_byte = phase ? 2'd1 : (rw_q ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1));
  assign tick      = (timer == dur_m1);

  always_comb begin
    case (state)
      BIT_HIGH: dur_m1 = TW'(2 * Q - 1);
      GAP:      dur_m1 = TW'(GAP_CYC - 1);
      default:  dur_m1 = TW'(Q - 1);
    endcase
  end

  // Byte in flight, selected by phase and byte index.
  always_comb begin
    tx_byte = 8'hFF;
    if (byte_cnt == 2'd0)                      tx_byte = {DEVICE_ID[7:1], phase};
    else if (phase)                            tx_byte = 8'hFF;
    else if (byte_cnt == 2'(ADDR_BYTES + 1))   tx_byte = data_q;
    else if (byte_cnt == 2'd1 && ADDR_BYTES == 2) tx_byte = addr_w[15:8];
    else                                       tx_byte = addr_w[7:0];
  end

  // Pad outputs. BIT_LOW and STOP_1 hold SIOD so it only moves in BIT_DATA.
  always_comb begin
    sioc = 1'b1;
    siod = 1'b1;
    oe   = 1'b1;
    case (state)
      START:    siod = 1'b0;
      BIT_LOW: begin
        sioc = 1'b0;
        siod = siod_q;
        oe   = oe_q;
      end
      BIT_DATA, BIT_HIGH: begin
        sioc = (state == BIT_HIGH);
        if (ninth) begin
          siod = 1'b1;
          oe   = rx_byte;          // ACK slot released, NA driven high
        end else if (rx_byte) begin
          siod = 1'b1;
          oe   = 1'b0;
        end else begin
          siod = tx_byte[~bit_cnt[2:0]];
        end
      end
      STOP_1: begin
        sioc = 1'b0;
        siod = siod_q;
      end
      STOP_2: begin
        sioc = 1'b0;
        siod = 1'b0;
      end
      STOP_3:   siod = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    phase_done = 1'b0;
    case (state)
      IDLE:     if (bus.i_start) state_nxt = START;
      START:    if (tick) state_nxt = BIT_LOW;
      BIT_LOW:  if (tick) state_nxt = BIT_DATA;
      BIT_DATA: if (tick) state_nxt = BIT_HIGH;
      BIT_HIGH: if (tick) state_nxt = (ninth && byte_cnt == last_byte) ? STOP_1 : BIT_LOW;
      STOP_1:   if (tick) state_nxt = STOP_2;
      STOP_2:   if (tick) state_nxt = STOP_3;
      STOP_3:   if (tick) state_nxt = STOP_4;
      STOP_4: begin
        if (tick) begin
          if (GAP_BITS > 0) state_nxt = GAP;
          else              phase_done = 1'b1;
        end
      end
      GAP:      if (tick) phase_done = 1'b1;
      default:  state_nxt = IDLE;
    endcase
    // A read's first phase chains straight into the second START.
    if (phase_done) state_nxt = (rw_q && !phase) ? START : IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      phase      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      siod_q     <= 1'b1;
      oe_q       <= 1'b1;
    end else begin
      state      <= state_nxt;
      siod_q     <= siod;
      oe_q       <= oe;
      rd_valid_q <= 1'b0;
      timer      <= (state == IDLE || tick) ? '0 : timer + 1'b1;
      if (state == IDLE && bus.i_start) begin
        rw_q   <= bus.i_rw;
        addr_q <= bus.i_address;
        data_q <= bus.i_data;
        phase  <= 1'b0;
      end
      if (state == BIT_HIGH && tick) begin
        if (ninth) begin
          bit_cnt  <= '0;
          byte_cnt <= byte_cnt + 1'b1;
        end else begin
          bit_cnt  <= bit_cnt + 1'b1;
        end
      end
      // Sample mid-way through SIOC high, well clear of both clock edges.
      if (state == BIT_HIGH && timer == TW'(Q - 1) && rx_byte && !ninth)
        rx_q <= {rx_q[6:0], bus.i_siod};
      if (phase_done) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        if (rw_q && !phase) begin
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (rw_q) begin
            rd_data_q  <= rx_q;
            rd_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_sioc     = sioc;
  assign bus.o_siod_out = siod;
  assign bus.o_siod_oe  = oe;
  assign bus.o_ready    = (state == IDLE);
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: three instances (8 clk/bit with 1- and 2-byte
// addresses, 10 clk/bit with 1-byte address) sharing one bus decoder and
// a slave model that answers reads; decoded tokens are checked against
// an expected-token queue.
module tb_sccb_master;
  localparam int Q   = 2;   // 8/4 and 10/4 both give 2
  localparam int GAP = 2;

  typedef struct {
    int         kind;   // 0 start, 1 byte, 2 stop
    logic [8:0] bits;   // 8 data bits then the 9th bit, line values
    logic [8:0] oe;     // master drive enable at each bit
  } tok_t;

  typedef struct {
    int         sel;
    logic       rw;
    logic [15:0] addr;
    logic [7:0] data;
    logic [7:0] sbyte;
    int         busy;
    logic [7:0] rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic       slave_val = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         gap_meas = 0;
  int         checks = 0;
  int         errors = 0;
  tok_t       sb[$];

  always #5 clk = ~clk;

  sccb_if #(.ADDR_BYTES(1)) if1 ();
  sccb_if #(.ADDR_BYTES(2)) if2 ();
  sccb_if #(.ADDR_BYTES(1)) if3 ();

  sccb_master #(.CLK_FREQUENCY(800000), .SCCB_FREQUENCY(100000), .ADDR_BYTES(1),
                .DEVICE_ID(8'h42), .GAP_BITS(GAP))
    dut1 (.i_clk(clk), .i_reset(rst), .bus(if1.master));
  sccb_master #(.CLK_FREQUENCY(800000), .SCCB_FREQUENCY(100000), .ADDR_BYTES(2),
                .DEVICE_ID(8'h42), .GAP_BITS(GAP))
    dut2 (.i_clk(clk), .i_reset(rst), .bus(if2.master));
  sccb_master #(.CLK_FREQUENCY(1000000), .SCCB_FREQUENCY(100000), .ADDR_BYTES(1),
                .DEVICE_ID(8'h42), .GAP_BITS(GAP))
    dut3 (.i_clk(clk), .i_reset(rst), .bus(if3.master));

  wire       mon_sioc  = (sel == 2'd0) ? if1.o_sioc     : (sel == 2'd1) ? if2.o_sioc     : if3.o_sioc;
  wire       mon_out   = (sel == 2'd0) ? if1.o_siod_out : (sel == 2'd1) ? if2.o_siod_out : if3.o_siod_out;
  wire       mon_oe    = (sel == 2'd0) ? if1.o_siod_oe  : (sel == 2'd1) ? if2.o_siod_oe  : if3.o_siod_oe;
  wire       mon_ready = (sel == 2'd0) ? if1.o_ready    : (sel == 2'd1) ? if2.o_ready    : if3.o_ready;
  wire       mon_rdv   = (sel == 2'd0) ? if1.o_rd_valid : (sel == 2'd1) ? if2.o_rd_valid : if3.o_rd_valid;
  wire [7:0] mon_rdd   = (sel == 2'd0) ? if1.o_rd_data  : (sel == 2'd1) ? if2.o_rd_data  : if3.o_rd_data;
  wire       sda       = mon_oe ? mon_out : slave_val;   // pulled-up open line

  assign if1.i_siod = sda;
  assign if2.i_siod = sda;
  assign if3.i_siod = sda;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_tok(input int kind, input logic [8:0] b, input logic [8:0] o);
    tok_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d bits %h, expected no token", kind, b);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == 1 && (e.bits !== b || e.oe !== o))) begin
        errors++;
        $display("FAIL sb_token: got kind %0d bits %h oe %h, expected kind %0d bits %h oe %h",
                 kind, b, o, e.kind, e.bits, e.oe);
      end
    end
  endtask

  function automatic tok_t mk(input int kind, input logic [7:0] v, input bit rx);
    tok_t t;
    t.kind = kind;
    t.bits = {v, 1'b1};
    t.oe   = rx ? 9'h001 : 9'h1FE;
    return t;
  endfunction

  // Expected bus tokens for one transaction.
  task automatic push_txn(input int ab, input logic rw, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] sbyte);
    sb.push_back(mk(0, 8'h00, 0));
    sb.push_back(mk(1, 8'h42, 0));
    if (ab == 2) sb.push_back(mk(1, a[15:8], 0));
    sb.push_back(mk(1, a[7:0], 0));
    if (!rw) sb.push_back(mk(1, d, 0));
    sb.push_back(mk(2, 8'h00, 0));
    if (rw) begin
      sb.push_back(mk(0, 8'h00, 0));
      sb.push_back(mk(1, 8'h43, 0));
      sb.push_back(mk(1, sbyte, 1));
      sb.push_back(mk(2, 8'h00, 0));
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic st, input logic rw,
                       input logic [15:0] a, input logic [7:0] d);
    case (s)
      2'd0: begin if1.i_start = st; if1.i_rw = rw; if1.i_address = a[7:0]; if1.i_data = d; end
      2'd1: begin if2.i_start = st; if2.i_rw = rw; if2.i_address = a;      if2.i_data = d; end
      default: begin if3.i_start = st; if3.i_rw = rw; if3.i_address = a[7:0]; if3.i_data = d; end
    endcase
  endtask

  task automatic set_start(input logic [1:0] s, input logic st);
    case (s)
      2'd0: if1.i_start = st;
      2'd1: if2.i_start = st;
      default: if3.i_start = st;
    endcase
  endtask

  // Entered on a negedge inside the busy window; returns on the negedge
  // where o_ready is back to 1. busy counts negedges seen with o_ready=0.
  task automatic wait_busy(input logic [1:0] s, input bit poke, output int busy, output int pulses);
    busy = 0;
    pulses = 0;
    while (!mon_ready && busy < 5000) begin
      busy++;
      if (mon_rdv) pulses++;
      if (poke) set_start(s, (busy == 50 || busy == 100));
      @(negedge clk);
    end
    if (busy >= 5000) $display("FAIL busy_timeout: got %0d cycles, expected ready", busy);
  endtask

  task automatic run_txn(input vec_t v, input bit poke, output int busy, output int pulses);
    int p;
    slave_byte = v.sbyte;
    push_txn((v.sel == 1) ? 2 : 1, v.rw, v.addr, v.data, v.sbyte);
    @(negedge clk);
    drive(2'(v.sel), 1'b1, v.rw, v.addr, v.data);
    @(negedge clk);
    set_start(2'(v.sel), 1'b0);
    wait_busy(2'(v.sel), poke, busy, p);
    if (mon_rdv) p++;
    @(negedge clk);
    if (mon_rdv) p++;
    pulses = p;
  endtask

  // Bus decoder and read-data slave, evaluated on the falling clock edge.
  initial begin
    bit         in_frame, rd_frame, p_scl, p_sda, cur_sda;
    int         bit_idx, byte_idx, rises, falls, last_rise, last_stop;
    logic [8:0] bits, oev;
    in_frame = 0; rd_frame = 0; p_scl = 1; p_sda = 1;
    bit_idx = 0; byte_idx = 0; rises = 0; falls = 0; last_rise = 0; last_stop = 0;
    bits = '0; oev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur_sda = sda;
      if (!mon_en) begin
        in_frame  = 0;
        slave_val = 1'b1;
      end else if (mon_sioc && p_scl && p_sda && !cur_sda) begin
        gap_meas = cyc - last_stop;
        in_frame = 1; rd_frame = 0; bit_idx = 0; byte_idx = 0; rises = 0; falls = 0;
        slave_val = 1'b1;
        check_tok(0, '0, '0);
      end else if (in_frame && mon_sioc && p_scl && !p_sda && cur_sda) begin
        last_stop = cyc;
        in_frame  = 0;
        check_tok(2, '0, '0);
      end else if (in_frame && mon_sioc && !p_scl) begin
        if (rises > 0) chk("sioc_period", cyc - last_rise, 4 * Q);
        rises++;
        last_rise = cyc;
        bits = {bits[7:0], cur_sda};
        oev  = {oev[7:0], mon_oe};
        bit_idx++;
        if (bit_idx == 9) begin
          check_tok(1, bits, oev);
          if (byte_idx == 0) rd_frame = bits[1];
          byte_idx++;
          bit_idx = 0;
        end
      end else if (in_frame && !mon_sioc && p_scl) begin
        if (falls > 0) chk("sioc_high", cyc - last_rise, 2 * Q);
        falls++;
        slave_val = (rd_frame && byte_idx == 1 && bit_idx < 8) ? slave_byte[7 - bit_idx] : 1'b1;
      end
      p_scl = mon_sioc;
      p_sda = cur_sda;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    vec_t v;
    int   busy, pulses, hi, b1, b2;
    vt[0] = '{0, 1'b0, 16'h0012, 8'h80, 8'h00, 242, 8'h00};
    vt[1] = '{1, 1'b1, 16'h300A, 8'h00, 8'h56, 412, 8'h56};
    vt[2] = '{0, 1'b1, 16'h000B, 8'h00, 8'hA5, 340, 8'hA5};
    vt[3] = '{0, 1'b0, 16'h0034, 8'h5A, 8'h00, 242, 8'hA5};
    vt[4] = '{1, 1'b0, 16'hBEEF, 8'h01, 8'h00, 314, 8'h56};
    vt[5] = '{2, 1'b0, 16'h0077, 8'hC3, 8'h00, 242, 8'h00};
    vt[6] = '{2, 1'b1, 16'h0001, 8'h00, 8'h3C, 340, 8'h3C};

    drive(2'd0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(2'd1, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(2'd2, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    chk("rst_dut1", {if1.o_sioc, if1.o_siod_out, if1.o_siod_oe, if1.o_ready, if1.o_rd_valid, if1.o_rd_data}, 13'h1E00);
    chk("rst_dut2", {if2.o_sioc, if2.o_siod_out, if2.o_siod_oe, if2.o_ready, if2.o_rd_valid, if2.o_rd_data}, 13'h1E00);
    chk("rst_dut3", {if3.o_sioc, if3.o_siod_out, if3.o_siod_oe, if3.o_ready, if3.o_rd_valid, if3.o_rd_data}, 13'h1E00);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      sel = 2'(vt[i].sel);
      @(negedge clk);
      run_txn(vt[i], 1'b0, busy, pulses);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d_rd_valid_pulses", i), pulses, vt[i].rw ? 1 : 0);
      chk($sformatf("vec%0d_rd_data", i), mon_rdd, vt[i].rd);
      chk($sformatf("vec%0d_sb_drained", i), sb.size(), 0);
    end

    // i_start pulses while busy are ignored.
    sel = 2'd0;
    v = '{0, 1'b0, 16'h0066, 8'h3E, 8'h00, 242, 8'hA5};
    run_txn(v, 1'b1, busy, pulses);
    chk("poke_busy", busy, 242);
    hi = 0;
    while (mon_ready && hi < 20) begin hi++; @(negedge clk); end
    chk("poke_no_reaccept", hi, 20);
    chk("poke_sb_drained", sb.size(), 0);

    // i_start held high: re-accepted on the first edge with o_ready=1.
    push_txn(1, 1'b0, 16'h0021, 8'h9C, 8'h00);
    push_txn(1, 1'b0, 16'h0021, 8'h9C, 8'h00);
    @(negedge clk);
    drive(2'd0, 1'b1, 1'b0, 16'h0021, 8'h9C);
    @(negedge clk);
    wait_busy(2'd0, 1'b0, b1, pulses);
    chk("b2b_busy1", b1, 242);
    hi = 0;
    while (mon_ready && hi < 10) begin hi++; @(negedge clk); end
    chk("b2b_ready_cycles", hi, 1);
    set_start(2'd0, 1'b0);
    wait_busy(2'd0, 1'b0, b2, pulses);
    chk("b2b_busy2", b2, 242);
    // stop-to-start: STOP_4, the GAP idle cells, one IDLE cycle
    chk("b2b_gap", gap_meas, Q + 4 * Q * GAP + 1);
    chk("b2b_sb_drained", sb.size(), 0);
    chk("b2b_rd_valid", pulses, 0);

    // Reset in the middle of the address byte.
    mon_en = 1'b0;
    @(negedge clk);
    drive(2'd0, 1'b1, 1'b0, 16'h0055, 8'hAA);
    @(negedge clk);
    set_start(2'd0, 1'b0);
    repeat (60) @(negedge clk);
    chk("busy_before_rst", mon_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pads", {mon_sioc, mon_out, mon_oe, mon_ready}, 4'hF);
    chk("rst_mid_rd", {mon_rdv, mon_rdd}, 9'h000);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    mon_en = 1'b1;
    v = '{0, 1'b0, 16'h00A7, 8'h18, 8'h00, 242, 8'h00};
    run_txn(v, 1'b0, busy, pulses);
    chk("post_rst_busy", busy, 242);
    chk("post_rst_rd_data", mon_rdd, 8'h00);
    chk("post_rst_sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_master.md
# sccb_master

Parameterised SCCB master for camera register access, successor to the write-only 8-bit-address transmitter in `config_camera`. It supports 8- or 16-bit register addresses, a configurable device ID and both write and read transactions. Reads use a 2-phase write followed by a 2-phase read, with SIOD released during read data. It sits between the camera configuration sequencer and the SIOC/SIOD pads; the top level builds the SIOD tristate from `o_siod_out`/`o_siod_oe`.

## Interface
- CLK_FREQUENCY, 25000000, system clock in Hz
- SCCB_FREQUENCY, 100000, SIOC bit rate in Hz; CLK_PER_BIT = CLK_FREQUENCY/SCCB_FREQUENCY must be >= 8 (elaboration assertion)
- ADDR_BYTES, 1, register address width in bytes, legal values 1 or 2
- DEVICE_ID, 8'h42, 8-bit write ID with bit0 = 0; the read ID is DEVICE_ID | 1
- GAP_BITS, 2, bus idle time after every stop, in bit cells
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  transaction request, accepted only when o_ready = 1
- i_rw  in  1  0 = write, 1 = read; latched on accept
- i_address  in  8*ADDR_BYTES  register address, MSB byte sent first; latched on accept
- i_data  in  8  write data; latched on accept, ignored for reads
- i_siod  in  1  SIOD pad input
- o_sioc  out  1  SIOC
- o_siod_out  out  1  SIOD drive value
- o_siod_oe  out  1  SIOD output enable; 1 = master drives the line
- o_ready  out  1  idle and able to accept a request
- o_rd_data  out  8  last read byte
- o_rd_valid  out  1  one-cycle pulse when o_rd_data is updated

## Operation
- Reset values: o_sioc=1, o_siod_out=1, o_siod_oe=1, o_ready=1, o_rd_data=0, o_rd_valid=0; FSM in IDLE with all counters 0.
- Reset mid-transaction returns all outputs to their reset values on the next edge. No stop condition is generated.
- Q = CLK_PER_BIT/4 (integer division); a bit cell is 4Q cycles.
- Accept: on an edge with i_start=1 and o_ready=1, latch the inputs, set o_ready<=0, and start the START state. i_start while o_ready=0 is ignored.
- FSM states: IDLE, START, BIT_LOW, BIT_DATA, BIT_HIGH, STOP_1, STOP_2, STOP_3, STOP_4, GAP.
  - Phase and byte indices select the byte in flight.
  - Every timed state lasts exactly its stated cycle count; there are no extra transition cycles.
- START (Q cycles): o_sioc=1, o_siod_out=0, o_siod_oe=1.
- Bit cell:
  - BIT_LOW (Q): o_sioc=0.
  - BIT_DATA (Q): o_sioc=0; SIOD is set to the bit value.
  - BIT_HIGH (2Q): o_sioc=1.
  - Bits are sent MSB first.
- Each byte is 9 bits: 8 data bits, then a 9th don't-care/NA bit.
  - 9th bit of a transmitted byte: o_siod_oe=0 (released).
  - 9th bit of a read byte (NA): the master drives 1.
- Read data bits: o_siod_oe=0. i_siod is sampled on the edge ending the first Q cycles of BIT_HIGH and shifted in MSB first.
- Stop, Q cycles each, o_siod_oe=1:
  - STOP_1: sioc=0.
  - STOP_2: siod=0.
  - STOP_3: sioc=1.
  - STOP_4: siod=1.
- GAP: 4Q*GAP_BITS cycles with sioc=1 and siod=1 driven.
- Write transaction: START, DEVICE_ID, address bytes, data, STOP, GAP. Then IDLE with o_ready<=1.
- Read transaction:
  - Phase 1: START, DEVICE_ID, address bytes, STOP, GAP.
  - Phase 2: START, DEVICE_ID|1, read byte, STOP, GAP.
  - Then o_rd_data is updated, o_rd_valid pulses for 1 cycle, and o_ready<=1, all on the same edge.
- o_rd_data holds its value until the next read completes. Writes never change it.
- Counters:
  - The timer is wide enough for max(2Q, 4Q*GAP_BITS) with no wrap.
  - The bit counter covers 0..8 and the byte counter covers 0..3.

## Timing
- Busy length counts the edges o_ready stays 0, measured from the accept edge.
- Write: Q*(5 + 36*(2+ADDR_BYTES) + 4*GAP_BITS) cycles.
- Read: Q*(5 + 36*(1+ADDR_BYTES) + 4*GAP_BITS) + Q*(5 + 72 + 4*GAP_BITS) cycles.
- With CLK_PER_BIT=8, ADDR_BYTES=1, GAP_BITS=2 (Q=2):
  - write = 242 cycles, read = 340 cycles.
  - With ADDR_BYTES=2: write = 314, read = 412.
- o_siod_out transitions only while o_sioc=0, except in START and STOP_4. SIOC high time per bit is 2Q cycles and low time is 2Q.
- Back-to-back: i_start held high is re-accepted on the first edge where o_ready=1. The GAP state guarantees bus idle time between transactions.

## Test plan
- Write, ADDR_BYTES=1, CLK_PER_BIT=8, addr 8'h12, data 8'h80:
  - Decoded bus shows start, 0x42, 0x12, 0x80, stop.
  - o_siod_oe=0 in each 9th bit.
  - o_ready is low for exactly 242 cycles.
- Read, ADDR_BYTES=2, addr 16'h300A, bus model returning 8'h56:
  - Phase 1 shows 0x42, 0x30, 0x0A, stop.
  - Phase 2 shows 0x43, read byte, NA=1, stop.
  - o_rd_data=8'h56 with a single o_rd_valid pulse.
  - o_ready is low for exactly 412 cycles.
- i_start pulses while busy: ignored. i_start held high continuously: the next transaction starts on the edge o_ready rises, and a 4Q*GAP_BITS idle gap is observed.
- i_reset asserted mid-byte: next edge gives sioc=1, siod_out=1, oe=1, o_ready=1. A new write afterwards completes correctly.
- Read returning 8'hA5, then a write: o_rd_data stays 8'hA5 and o_rd_valid stays 0 during the write.
- Timing check at CLK_PER_BIT=10 (Q=2): each bit cell is 8 cycles, with SIOD stable throughout every SIOC-high phase.
